// File: rtl/RSA_pkg.sv
// rtl/RSA_pkg.sv - Shared RSA widths, key/word types and the word-stream record.
package RSA_pkg;

  localparam int MOD_WIDTH = 256;
  localparam int INT_WIDTH = 32;

  typedef logic [MOD_WIDTH-1:0] KeyType;
  typedef logic [INT_WIDTH-1:0] IntType;

  // Words per key on the narrow side; shared with the deserializer.
  localparam int RSA_NWORD = MOD_WIDTH / INT_WIDTH;

  typedef struct packed {
    logic   last;
    IntType data;
  } RSAWordStream;

endpackage

// File: rtl/rsa_key_serializer.sv
// rtl/rsa_key_serializer.sv - Splits one full-width RSA result into a stream of bus words.
module rsa_key_serializer
  import RSA_pkg::*;
#(
  parameter int KEY_W     = MOD_WIDTH,
  parameter int WORD_W    = INT_WIDTH,
  parameter bit MSW_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic [KEY_W-1:0]  i_data,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [WORD_W-1:0] o_data,
  output logic              o_last
);

  localparam int NWORD = KEY_W / WORD_W;
  localparam int CNT_W = (NWORD > 1) ? $clog2(NWORD) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NWORD - 1);

  generate
    if (KEY_W % WORD_W != 0) begin : g_bad_width
      $error("rsa_key_serializer: KEY_W must be a multiple of WORD_W");
    end
  endgenerate

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [KEY_W-1:0]   sr_q, sr_d;
  logic               at_last;
  logic               o_xfer;
  logic               accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    at_last = (state_q == SEND) && (cnt_q == LAST_CNT);
    o_xfer  = (state_q == SEND) && o_ready;
    // Accepting on the final transfer lets back-to-back keys stream without a bubble.
    i_ready = (state_q == IDLE) || (o_xfer && at_last);
    accept  = i_valid && i_ready;

    if (accept) begin
      sr_d    = i_data;
      cnt_d   = '0;
      state_d = SEND;
    end else if (o_xfer) begin
      if (at_last) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      sr_d = MSW_FIRST ? (sr_q << WORD_W) : (sr_q >> WORD_W);
    end
  end

  assign o_valid = (state_q == SEND);
  assign o_last  = at_last;

  generate
    if (MSW_FIRST) begin : g_msw
      assign o_data = sr_q[KEY_W-1 -: WORD_W];
    end else begin : g_lsw
      assign o_data = sr_q[WORD_W-1:0];
    end
  endgenerate

endmodule

// File: tb/tb_rsa_key_serializer.sv
// tb/tb_rsa_key_serializer.sv - Self-checking bench for rsa_key_serializer (LSW- and MSW-first).
module tb_rsa_key_serializer;

  localparam int KW = 256;
  localparam int WW = 32;
  localparam int NW = KW / WW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_valid = 1'b0;
  logic [KW-1:0] i_data = '0;
  logic          o_ready = 1'b0;

  logic          i_ready0, o_valid0, o_last0;
  logic [WW-1:0] o_data0;
  logic          i_ready1, o_valid1, o_last1;
  logic [WW-1:0] o_data1;

  always #5 clk = ~clk;

  rsa_key_serializer #(.KEY_W(KW), .WORD_W(WW), .MSW_FIRST(1'b0)) u_lsw (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(i_ready0), .i_data(i_data),
    .o_valid(o_valid0), .o_ready(o_ready), .o_data(o_data0), .o_last(o_last0)
  );

  rsa_key_serializer #(.KEY_W(KW), .WORD_W(WW), .MSW_FIRST(1'b1)) u_msw (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(i_ready1), .i_data(i_data),
    .o_valid(o_valid1), .o_ready(o_ready), .o_data(o_data1), .o_last(o_last1)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference: each accepted key becomes NW {last,word} entries in send order.
  logic [WW:0] q0[$];
  logic [WW:0] q1[$];

  typedef struct {
    logic [WW-1:0] lsw;
    logic [WW-1:0] msw;
    logic          last;
  } vec_t;
  vec_t tab[NW];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic push_key(input logic [KW-1:0] d);
    for (int i = 0; i < NW; i++) begin
      q0.push_back({(i == NW - 1), d[i*WW +: WW]});
      q1.push_back({(i == NW - 1), d[(NW-1-i)*WW +: WW]});
    end
  endtask

  // One clock cycle: apply inputs at the falling edge, then check against the model.
  task automatic drive(input logic iv, input logic [KW-1:0] d, input logic ordy);
    logic exp_ready;
    @(negedge clk);
    i_valid = iv;
    i_data  = d;
    o_ready = ordy;
    #1;
    exp_ready = (q0.size() == 0) || (ordy && q0.size() == 1);
    chk("i_ready_lsw", 64'(i_ready0), 64'(exp_ready));
    chk("i_ready_msw", 64'(i_ready1), 64'(exp_ready));
    chk("o_valid_lsw", 64'(o_valid0), 64'(q0.size() != 0));
    chk("o_valid_msw", 64'(o_valid1), 64'(q1.size() != 0));
    if (q0.size() != 0) begin
      chk("word_lsw", 64'({o_last0, o_data0}), 64'(q0[0]));
      chk("word_msw", 64'({o_last1, o_data1}), 64'(q1[0]));
      if (ordy) begin
        void'(q0.pop_front());
        void'(q1.pop_front());
      end
    end else begin
      chk("o_last_idle", 64'({o_last0, o_last1}), 64'(0));
    end
    if (iv && exp_ready) push_key(d);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (q0.size() != 0 && guard < 40) begin
      drive(1'b0, '0, 1'b1);
      guard++;
    end
    chk("drain_done", 64'(q0.size()), 64'(0));
  endtask

  function automatic logic [KW-1:0] rand_key();
    logic [KW-1:0] k;
    for (int i = 0; i < NW; i++) k[i*WW +: WW] = $urandom;
    return k;
  endfunction

  logic [KW-1:0] k1, kb, ka, kc, kd, ke;
  int xfers, pulses, b_at;
  logic b_taken;
  logic [3:0] bp_pat;

  initial begin
    for (int i = 0; i < NW; i++) begin
      k1[i*WW +: WW] = WW'(i + 1);
      kb[i*WW +: WW] = 32'hDEADBEEF ^ WW'(i);
      tab[i].lsw  = WW'(i + 1);
      tab[i].msw  = WW'(NW - i);
      tab[i].last = (i == NW - 1);
    end

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_i_ready", 64'({i_ready0, i_ready1}), 64'(2'b11));
    chk("rst_o_valid", 64'({o_valid0, o_valid1}), 64'(0));
    chk("rst_o_last", 64'({o_last0, o_last1}), 64'(0));
    chk("rst_o_data", 64'({o_data0, o_data1}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Basic stream, table-driven: one word per cycle starting one cycle after accept
    drive(1'b1, k1, 1'b1);
    chk("accept_cycle_no_valid", 64'(o_valid0), 64'(0));
    for (int i = 0; i < NW; i++) begin
      drive(1'b0, '0, 1'b1);
      chk("tab_lsw_data", 64'(o_data0), 64'(tab[i].lsw));
      chk("tab_msw_data", 64'(o_data1), 64'(tab[i].msw));
      chk("tab_last", 64'({o_last0, o_last1}), 64'({tab[i].last, tab[i].last}));
      chk("tab_valid", 64'({o_valid0, o_valid1}), 64'(2'b11));
    end
    drive(1'b0, '0, 1'b1);
    chk("after_last_idle", 64'({o_valid0, o_valid1}), 64'(0));

    // Backpressure 1,0,0,1
    bp_pat = 4'b1001;
    drive(1'b1, kb, 1'b1);
    xfers = 0;
    for (int c = 0; c < 64 && q0.size() != 0; c++) begin
      drive(1'b0, '0, bp_pat[3 - (c % 4)]);
      if (bp_pat[3 - (c % 4)] && o_valid0) xfers++;
    end
    chk("bp_transfers", 64'(xfers), 64'(NW));

    // Back-to-back A then B with i_valid held high
    ka = rand_key();
    drive(1'b1, ka, 1'b1);
    xfers = 0; pulses = 0; b_taken = 1'b0; b_at = -1;
    for (int c = 0; c < 2 * NW; c++) begin
      drive(!b_taken, k1 ^ ka, 1'b1);
      if (o_valid0) xfers++;
      if (!b_taken && i_ready0) begin
        pulses++;
        b_taken = 1'b1;
        b_at = c;
      end
    end
    chk("b2b_words", 64'(xfers), 64'(2 * NW));
    chk("b2b_ready_pulses", 64'(pulses), 64'(1));
    chk("b2b_reload_cycle", 64'(b_at), 64'(NW - 1));
    drive(1'b0, '0, 1'b1);
    chk("b2b_idle_after", 64'(o_valid0), 64'(0));

    // Reset mid-key
    kc = 256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_FFFFFFFF;
    drive(1'b1, kc, 1'b1);
    for (int c = 0; c < 3; c++) drive(1'b0, '0, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_o_valid", 64'({o_valid0, o_valid1}), 64'(0));
    chk("midrst_i_ready", 64'({i_ready0, i_ready1}), 64'(2'b11));
    chk("midrst_o_last", 64'({o_last0, o_last1}), 64'(0));
    q0.delete();
    q1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    kc = rand_key();
    drive(1'b1, kc, 1'b1);
    drain();

    // Mid-stream i_valid with a different key is ignored
    kd = rand_key();
    ke = ~kd;
    drive(1'b1, kd, 1'b1);
    drive(1'b0, '0, 1'b1);
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, ke, (c != 2));
      chk("ignore_i_ready", 64'(i_ready0), 64'(0));
    end
    i_valid = 1'b0;
    drain();

    // Randomised traffic against the queue model
    for (int c = 0; c < 400; c++) begin
      drive(($urandom_range(0, 1) == 1), rand_key(), ($urandom_range(0, 9) < 7));
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
